// File: rtl/bitwise_stream_pkg.sv
// Shared definitions for the bitwise stream unit: op encodings, FSM states
// and the single-bit operator helper used by the per-bit datapath.
package bitwise_stream_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  // One bit of the selected bitwise operation; no carries between bits.
  function automatic logic bit_op(input logic [1:0] op_sel,
                                  input logic       a_bit,
                                  input logic       b_bit);
    logic res;
    case (op_sel)
      OP_AND:  res = a_bit & b_bit;
      OP_OR:   res = a_bit | b_bit;
      OP_XOR:  res = a_bit ^ b_bit;
      OP_XNOR: res = ~(a_bit ^ b_bit);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bitwise_stream_unit_op.sv
// Purely combinational per-bit operator: r = a op b, one generate slice per bit.
module bitwise_op_unit
  import bitwise_stream_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] r
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign r[i] = bit_op(op, a[i], b[i]);
  end

endmodule

// File: rtl/bitwise_stream_unit.sv
// Handshaked bitwise operator with pass-through and XOR-fold (checksum)
// modes. One registered output stage; a frame that reaches MAX_BEATS without
// in_last is force-closed and flagged with out_ovf.
module bitwise_stream_unit
  import bitwise_stream_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             accum_en,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  // Even parity helper kept alongside the data it protects.
  function automatic logic calc_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [WIDTH-1:0] w_r;
  logic             w_accept;
  logic             w_emit;
  logic [WIDTH-1:0] w_emit_f;
  logic [CNT_W-1:0] w_emit_cnt;
  logic             w_emit_ovf;
  logic [CNT_W-1:0] w_cnt_inc;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_f;
  logic             r_parity;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  bitwise_op_unit #(.WIDTH(WIDTH)) u_op (
    .a  (a),
    .b  (b),
    .op (op),
    .r  (w_r)
  );

  // A beat may enter whenever the output slot is empty or draining this cycle,
  // which also lets an emit land back-to-back with the handshake.
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next-state, accumulator and emit decision for the accepted beat.
  always_comb begin
    w_emit      = 1'b0;
    w_emit_f    = w_r;
    w_emit_cnt  = CNT_W'(1);
    w_emit_ovf  = 1'b0;
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (!accum_en || in_last) begin
            // Pass beat or single-beat frame: emit the beat result directly.
            w_emit = 1'b1;
          end else begin
            w_state_nxt = S_ACC;
            w_acc_nxt   = w_r;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        S_ACC: begin
          w_emit_f = r_acc ^ w_r;
          if (in_last) begin
            w_emit      = 1'b1;
            w_emit_cnt  = w_cnt_inc;
            w_state_nxt = S_IDLE;
            w_acc_nxt   = {WIDTH{1'b0}};
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else if (w_cnt_inc == CNT_W'(MAX_BEATS)) begin
            // Frame is full without in_last: close it and flag overflow.
            w_emit      = 1'b1;
            w_emit_cnt  = w_cnt_inc;
            w_emit_ovf  = 1'b1;
            w_state_nxt = S_IDLE;
            w_acc_nxt   = {WIDTH{1'b0}};
            w_cnt_nxt   = {CNT_W{1'b0}};
          end else begin
            w_acc_nxt = r_acc ^ w_r;
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = {WIDTH{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Frame state: FSM state, running XOR fold and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= {WIDTH{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output slot: load on emit, hold while stalled, clear after handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_f         <= {WIDTH{1'b0}};
      r_parity    <= 1'b0;
      r_count     <= {CNT_W{1'b0}};
      r_ovf       <= 1'b0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_f         <= w_emit_f;
      r_parity    <= calc_parity(w_emit_f);
      r_count     <= w_emit_cnt;
      r_ovf       <= w_emit_ovf;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_valid  = r_out_valid;
  assign f          = r_f;
  assign out_parity = r_parity;
  assign out_count  = r_count;
  assign out_ovf    = r_ovf;

endmodule

// File: tb/tb_bitwise_stream_unit.sv
// Self-checking bench: frame-level reference model plus directed vectors
// with hand-computed results.
module tb_bitwise_stream_unit;

  localparam int W  = 16;
  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);

  localparam logic [1:0] T_AND  = 2'b00;
  localparam logic [1:0] T_OR   = 2'b01;
  localparam logic [1:0] T_XOR  = 2'b10;
  localparam logic [1:0] T_XNOR = 2'b11;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    op;
  logic          accum_en;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  f;
  logic          out_parity;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  bitwise_stream_unit #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .accum_en   (accum_en),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .f          (f),
    .out_parity (out_parity),
    .out_count  (out_count),
    .out_ovf    (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [W-1:0]  f;
    logic [CW-1:0] cnt;
    logic          ovf;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0]  f;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          par;
  } got_t;

  exp_t exp_q[$];
  got_t got_q[$];

  // Model of the frame in progress: list of beat results folded so far.
  logic [W-1:0] frame_q[$];

  logic          prev_valid = 1'b0;
  logic          prev_hs    = 1'b0;
  logic [W-1:0]  held_f;
  logic [CW-1:0] held_cnt;
  logic          held_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      T_AND:   return x & y;
      T_OR:    return x | y;
      T_XOR:   return x ^ y;
      default: return ~(x ^ y);
    endcase
  endfunction

  // Close the modelled frame: XOR of all its beat results.
  task automatic close_frame(input logic ovf_flag);
    exp_t e;
    e.f = '0;
    foreach (frame_q[i]) e.f = e.f ^ frame_q[i];
    e.cnt = CW'(frame_q.size());
    e.ovf = ovf_flag;
    e.cyc = cyc;
    exp_q.push_back(e);
    frame_q.delete();
  endtask

  // Compare process: outputs, hold stability and in_ready rule every cycle,
  // then feed any accepted beat into the model.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      frame_q.delete();
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      check("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (prev_valid && !prev_hs) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_f", {16'd0, f}, {16'd0, held_f});
        check("hold_count", {29'd0, out_count}, {29'd0, held_cnt});
        check("hold_ovf", {31'd0, out_ovf}, {31'd0, held_ovf});
      end
      if (out_valid && (!prev_valid || prev_hs)) begin
        got_t g;
        g.f = f; g.cnt = out_count; g.ovf = out_ovf; g.par = out_parity;
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got f=%0h with no result due", f);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("model_f", {16'd0, f}, {16'd0, e.f});
          check("model_count", {29'd0, out_count}, {29'd0, e.cnt});
          check("model_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
          check("model_parity", {31'd0, out_parity}, {31'd0, ^e.f});
          check("model_latency", cyc, e.cyc + 1);
        end
      end
      held_f     = f;
      held_cnt   = out_count;
      held_ovf   = out_ovf;
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      if (in_valid && in_ready) begin
        logic first;
        first = (frame_q.size() == 0);
        frame_q.push_back(ref_op(op, a, b));
        if (first && (!accum_en || in_last)) close_frame(1'b0);
        else if (!first && in_last) close_frame(1'b0);
        else if (frame_q.size() == MB) close_frame(1'b1);
      end
    end
  end

  // Present one beat and wait (bounded) until it is accepted.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [1:0] top,
                      input logic tacc, input logic tlast);
    logic done;
    a = ta; b = tb_v; op = top; accum_en = tacc; in_last = tlast;
    in_valid = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    @(posedge clk);
    #1;
    check("send_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int idx, input logic [W-1:0] ef, input logic [CW-1:0] ec,
                            input logic eo, input logic ep, input string name);
    if (got_q.size() > idx) begin
      check({name, "_f"}, {16'd0, got_q[idx].f}, {16'd0, ef});
      check({name, "_count"}, {29'd0, got_q[idx].cnt}, {29'd0, ec});
      check({name, "_ovf"}, {31'd0, got_q[idx].ovf}, {31'd0, eo});
      check({name, "_parity"}, {31'd0, got_q[idx].par}, {31'd0, ep});
    end else begin
      checks++;
      failures++;
      $display("FAIL %s_missing: got %0d outputs expected more than %0d", name, got_q.size(), idx);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_f"}, {16'd0, f}, 32'd0);
    check({name, "_parity"}, {31'd0, out_parity}, 32'd0);
    check({name, "_count"}, {29'd0, out_count}, 32'd0);
    check({name, "_ovf"}, {31'd0, out_ovf}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 2'b00;
    accum_en = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Pass mode, back-to-back XOR beats.
    got_q.delete();
    send(16'haaaa, 16'h00ff, T_XOR, 1'b0, 1'b0);
    send(16'h0f0f, 16'h3333, T_XOR, 1'b0, 1'b0);
    drain();
    check("pass_outputs", got_q.size(), 32'd2);
    expect_out(0, 16'haa55, 3'd1, 1'b0, 1'b0, "pass0");
    expect_out(1, 16'h3c3c, 3'd1, 1'b0, 1'b0, "pass1");

    // Op coverage.
    got_q.delete();
    send(16'haaaa, 16'h00ff, T_AND,  1'b0, 1'b0);
    send(16'haaaa, 16'h00ff, T_OR,   1'b0, 1'b0);
    send(16'h0f0f, 16'h3333, T_XNOR, 1'b0, 1'b0);
    send(16'h0001, 16'h0000, T_XOR,  1'b0, 1'b0);
    drain();
    expect_out(0, 16'h00aa, 3'd1, 1'b0, 1'b0, "op_and");
    expect_out(1, 16'haaff, 3'd1, 1'b0, 1'b0, "op_or");
    expect_out(2, 16'hc3c3, 3'd1, 1'b0, 1'b0, "op_xnor");
    expect_out(3, 16'h0001, 3'd1, 1'b0, 1'b1, "op_xor_par");

    // Three-beat accumulate frame.
    got_q.delete();
    send(16'haaaa, 16'h00ff, T_XOR, 1'b1, 1'b0);
    send(16'h0f0f, 16'h3333, T_XOR, 1'b0, 1'b0);
    send(16'hffff, 16'h0000, T_XOR, 1'b0, 1'b1);
    drain();
    check("acc_outputs", got_q.size(), 32'd1);
    expect_out(0, 16'h6996, 3'd3, 1'b0, 1'b0, "acc");

    // Forced close at MAX_BEATS, then a fresh pass beat.
    got_q.delete();
    for (int i = 0; i < MB; i++) send(16'h0001, 16'h0000, T_XOR, 1'b1, 1'b0);
    send(16'h0f0f, 16'h3333, T_XOR, 1'b0, 1'b0);
    drain();
    check("ovf_outputs", got_q.size(), 32'd2);
    expect_out(0, 16'h0000, 3'd4, 1'b1, 1'b0, "ovf");
    expect_out(1, 16'h3c3c, 3'd1, 1'b0, 1'b0, "after_ovf");

    // Backpressure: hold first result, stall second beat, then release.
    got_q.delete();
    out_ready = 1'b0;
    send(16'haaaa, 16'h00ff, T_XOR, 1'b0, 1'b0);
    fork
      send(16'h0f0f, 16'h3333, T_XOR, 1'b0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_f", {16'd0, f}, 32'h0000aa55);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_outputs", got_q.size(), 32'd2);
    expect_out(0, 16'haa55, 3'd1, 1'b0, 1'b0, "bp0");
    expect_out(1, 16'h3c3c, 3'd1, 1'b0, 1'b0, "bp1");

    // Reset while a result is held.
    out_ready = 1'b0;
    send(16'hffff, 16'h00ff, T_AND, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    check("held_before_rst", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_held");
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset mid-frame, then a single pass beat.
    send(16'h1111, 16'h0000, T_XOR, 1'b1, 1'b0);
    send(16'h2222, 16'h0000, T_XOR, 1'b1, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    got_q.delete();
    send(16'h0f0f, 16'h3333, T_XOR, 1'b0, 1'b0);
    drain();
    check("post_rst_outputs", got_q.size(), 32'd1);
    expect_out(0, 16'h3c3c, 3'd1, 1'b0, 1'b0, "post_rst");

    drain();
    check("no_pending_results", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitwise_stream_unit.md
Name: bitwise_stream_unit

Overview:
Parametrised, handshaked successor to the fixed 16-bit combinational XOR block. Each beat applies a per-beat selectable bitwise operation to two WIDTH-bit operands. Results are either passed through one per beat (pass mode) or XOR-folded across a frame into one checksum word (accumulate mode). Sits between a valid/ready producer and consumer in datapath and checksum logic, with a registered output.

Parameters:
WIDTH, 16, operand/result width in bits (>=1)
MAX_BEATS, 256, maximum beats folded into one accumulate frame before forced emit (>=2)
CNT_W, $clog2(MAX_BEATS+1), width of beat counter/out_count (derived; do not override)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  2  00 AND, 01 OR, 10 XOR, 11 XNOR; sampled per accepted beat
accum_en  in  1  1 = accumulate mode; sampled only on first beat of a frame
in_last  in  1  marks final beat of an accumulate frame; ignored in pass mode
out_valid  out  1  result valid
out_ready  in  1  consumer accepts when out_valid && out_ready
f  out  WIDTH  result word
out_parity  out  1  XOR-reduction of f, registered with f
out_count  out  CNT_W  number of beats contributing to f (1 in pass mode)
out_ovf  out  1  frame force-closed at MAX_BEATS without in_last

Behaviour:
- Reset (async, rst=1): out_valid=0, f=0, out_parity=0, out_count=0, out_ovf=0, acc=0, cnt=0, state=S_IDLE. Reset mid-frame discards the partial accumulation and any held output. No output is emitted after release.
- Per-beat result r = a op b, bitwise, WIDTH bits, no carries.
- in_ready = !out_valid || out_ready, combinational. Same rule in every state.
- Output register: loads on an emit event and sets out_valid=1. It holds f, parity, count and ovf stable while out_valid && !out_ready. out_valid clears on handshake unless a new emit occurs in the same cycle, in which case it stays 1 with the new data (back-to-back, full throughput).
- Latency: 1 cycle from accepting an emitting beat to out_valid.
- States:
  - S_IDLE, accepted beat:
    - accum_en=0: emit r, count=1, ovf=0; stay in S_IDLE.
    - accum_en=1 && in_last: emit r, count=1; stay in S_IDLE.
    - accum_en=1 && !in_last: acc<=r, cnt<=1; go to S_ACC.
  - S_ACC, accepted beat (accum_en ignored):
    - in_last: emit acc^r, count=cnt+1, ovf=0; go to S_IDLE.
    - !in_last && cnt+1==MAX_BEATS: emit acc^r, count=MAX_BEATS, ovf=1; go to S_IDLE.
    - otherwise: acc<=acc^r, cnt<=cnt+1.
  - No accepted beat: state and acc unchanged.
- Non-emitting beats in S_ACC still require in_ready=1. An uncollected previous result therefore stalls the frame; no beat is ever dropped.
- in_valid must hold a, b, op, accum_en and in_last stable until accepted. Inputs are don't-care while in_valid=0.

Decomposition:
- Package bitwise_stream_pkg: op encoding constants (OP_AND, OP_OR, OP_XOR, OP_XNOR), state enum (S_IDLE, S_ACC).
- Sub-module bitwise_op_unit: purely combinational, parametrised WIDTH, per-bit generate loop computing r from a, b, op. Reusable elsewhere.
- Top module holds FSM, accumulator, counter and output register.

Test Plan:
- Pass mode, XOR, out_ready=1: a=16'haaaa, b=16'h00ff, then a=16'h0f0f, b=16'h3333 -> f=16'haa55 then 16'h3c3c on consecutive cycles, each 1 cycle after acceptance; out_count=1, out_parity=0.
- Op coverage: AND aaaa/00ff -> 00aa; OR aaaa/00ff -> aaff; XNOR 0f0f/3333 -> c3c3; XOR 0001/0000 -> f=0001, out_parity=1.
- Accumulate frame, XOR beats (aaaa,00ff), (0f0f,3333), (ffff,0000, in_last=1) -> exactly one output, f=16'h6996, out_count=3, out_ovf=0, 1 cycle after last beat accepted.
- Overflow with MAX_BEATS=4, 4 XOR beats (0001,0000) with in_last=0 -> f=16'h0000, out_count=4, out_ovf=1. Next beat starts a fresh frame.
- Backpressure: out_ready=0 after first pass result -> out_valid stays 1, f/count stable, in_ready=0, no further beats accepted. Raising out_ready drains and resumes with no loss or duplication.
- Reset mid-frame: assert rst after 2 accumulate beats -> all outputs 0 immediately (async). After release, a single pass beat XOR 0f0f/3333 -> f=3c3c, out_count=1.
